// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel raster-to-window stage.
// Contents:
//   pixel_t      8-bit grayscale sample
//   IMG_W_DEF    default pixels per row
//   IMG_H_DEF    default rows per frame
//   W_*          window row/column/tap index constants (row-major, 0 = top-left)
package sobel_pkg;

    typedef logic [7:0] pixel_t;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    // Window geometry: rows top..bottom, columns left..right.
    localparam int W_TAPS    = 3;
    localparam int W_ROW_TOP = 0;
    localparam int W_ROW_MID = 1;
    localparam int W_ROW_BOT = 2;
    localparam int W_COL_L   = 0;
    localparam int W_COL_C   = 1;
    localparam int W_COL_R   = 2;
    localparam int W_CENTRE  = W_ROW_MID * W_TAPS + W_COL_C;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle of the Sobel window generator.
// Signals:
//   pix_valid_i  pixel qualifier
//   sof_i        start of frame, meaningful only with pix_valid_i
//   pix_i        grayscale pixel
//   sobel_en     one-cycle window-valid pulse
//   w_0..w_8     3x3 window, row-major (w_4 is the centre)
//   eof_o        one-cycle pulse after the last pixel of a frame
// Modports: slave = window generator, master = pixel source / window sink.
interface sobel_window_gen_if;
    import sobel_pkg::*;

    logic   pix_valid_i;
    logic   sof_i;
    pixel_t pix_i;
    logic   sobel_en;
    pixel_t w_0, w_1, w_2, w_3, w_4, w_5, w_6, w_7, w_8;
    logic   eof_o;

    modport slave (
        input  pix_valid_i, sof_i, pix_i,
        output sobel_en, w_0, w_1, w_2, w_3, w_4, w_5, w_6, w_7, w_8, eof_o
    );

    modport master (
        output pix_valid_i, sof_i, pix_i,
        input  sobel_en, w_0, w_1, w_2, w_3, w_4, w_5, w_6, w_7, w_8, eof_o
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// One-row delay line for the window generator.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (blocks writes while asserted)
//   en     write the addressed entry this cycle
//   addr   column index
//   din    new sample for the addressed column
//   dout   sample stored at addr before this cycle's write (read-before-write)
// Contents are intentionally not reset.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  pixel_t        din,
    output pixel_t        dout
);

    pixel_t mem [DEPTH];

    // Combinational read returns the old entry; the write lands at the edge.
    assign dout = mem[addr];

    always_ff @(posedge clk_i) begin
        if (en && !rst_i) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-to-window stage: tracks (col,row) of each accepted pixel, keeps two
// rows of history and emits a 3x3 window with a one-cycle sobel_en pulse for
// every pixel at x>=2, y>=2 (window centre at x-1, y-1).
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   bus    sobel_window_gen_if.slave (pixel stream in, window/enable/eof out)
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sobel_window_gen_if.slave   bus
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_reg, col_next, cur_col;
    logic [RW-1:0] row_reg, row_next, cur_row;
    logic          accept;
    logic          sobel_en_reg, eof_reg;
    pixel_t        t1, t2;
    pixel_t        row_in [W_TAPS];

    assign accept = bus.pix_valid_i;

    // A qualified sof_i relabels the current pixel as (0,0), overriding the counters.
    always_comb begin
        cur_col  = bus.sof_i ? '0 : col_reg;
        cur_row  = bus.sof_i ? '0 : row_reg;
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_next = '0;
                row_next = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_next = cur_col + CW'(1);
                row_next = cur_row;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_reg      <= '0;
            row_reg      <= '0;
            sobel_en_reg <= 1'b0;
            eof_reg      <= 1'b0;
        end else begin
            col_reg      <= col_next;
            row_reg      <= row_next;
            sobel_en_reg <= accept && (cur_col >= CW'(2)) && (cur_row >= RW'(2));
            eof_reg      <= accept && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        end
    end

    // lb0 delays by one row (y-1); lb1 takes lb0's old value, giving y-2.
    sobel_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (accept),
        .addr  (cur_col),
        .din   (bus.pix_i),
        .dout  (t1)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (accept),
        .addr  (cur_col),
        .din   (t1),
        .dout  (t2)
    );

    assign row_in[W_ROW_TOP] = t2;
    assign row_in[W_ROW_MID] = t1;
    assign row_in[W_ROW_BOT] = bus.pix_i;

    // One 3-tap shift register per window row; newest sample enters on the right.
    generate
        for (genvar gi = 0; gi < W_TAPS; gi++) begin : g_row
            pixel_t tap_reg [W_TAPS];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    tap_reg[W_COL_L] <= '0;
                    tap_reg[W_COL_C] <= '0;
                    tap_reg[W_COL_R] <= '0;
                end else if (accept) begin
                    tap_reg[W_COL_L] <= tap_reg[W_COL_C];
                    tap_reg[W_COL_C] <= tap_reg[W_COL_R];
                    tap_reg[W_COL_R] <= row_in[gi];
                end
            end
        end
    endgenerate

    assign bus.w_0 = g_row[W_ROW_TOP].tap_reg[W_COL_L];
    assign bus.w_1 = g_row[W_ROW_TOP].tap_reg[W_COL_C];
    assign bus.w_2 = g_row[W_ROW_TOP].tap_reg[W_COL_R];
    assign bus.w_3 = g_row[W_ROW_MID].tap_reg[W_COL_L];
    assign bus.w_4 = g_row[W_ROW_MID].tap_reg[W_COL_C];
    assign bus.w_5 = g_row[W_ROW_MID].tap_reg[W_COL_R];
    assign bus.w_6 = g_row[W_ROW_BOT].tap_reg[W_COL_L];
    assign bus.w_7 = g_row[W_ROW_BOT].tap_reg[W_COL_C];
    assign bus.w_8 = g_row[W_ROW_BOT].tap_reg[W_COL_R];

    assign bus.sobel_en = sobel_en_reg;
    assign bus.eof_o    = eof_reg;

endmodule
